// File: rtl/sm_config_loader.sv
// sm_config_loader: parity-checked serial loader that atomically commits switch_matrix mux selects
module sm_config_loader #(
  parameter int channel_width = 8,
  parameter int CTRL_BITS     = 2,
  localparam int SIDE_BITS    = channel_width / 2 * CTRL_BITS,
  localparam int CFG_BITS     = 4 * SIDE_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  input  logic                 cfg_data,
  output logic                 cfg_ready,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic [SIDE_BITS-1:0] ctrl_left,
  output logic [SIDE_BITS-1:0] ctrl_right,
  output logic [SIDE_BITS-1:0] ctrl_top,
  output logic [SIDE_BITS-1:0] ctrl_bottom
);
  localparam int CW = $clog2(CFG_BITS);
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                par_q, par_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] ctrl_q, ctrl_d;
  logic                beat;
  assign beat        = cfg_valid && state_q != IDLE;
  assign cfg_ready   = state_q != IDLE;
  assign cfg_busy    = state_q != IDLE;
  assign cfg_done    = done_q;
  assign cfg_err     = err_q;
  assign ctrl_left   = ctrl_q[SIDE_BITS-1:0];
  assign ctrl_right  = ctrl_q[2*SIDE_BITS-1:SIDE_BITS];
  assign ctrl_top    = ctrl_q[3*SIDE_BITS-1:2*SIDE_BITS];
  assign ctrl_bottom = ctrl_q[4*SIDE_BITS-1:3*SIDE_BITS];
  // Next state: start (re)arms the frame and wins over any beat in the same cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    done_d   = 1'b0;
    err_d    = err_q;
    shadow_d = shadow_q;
    ctrl_d   = ctrl_q;
    if (cfg_start) begin
      state_d  = SHIFT;
      cnt_d    = '0;
      par_d    = 1'b0;
      err_d    = 1'b0;
      shadow_d = '0;
    end else if (beat && state_q == SHIFT) begin
      shadow_d[cnt_q] = cfg_data;
      par_d           = par_q ^ cfg_data;
      cnt_d           = cnt_q + 1'b1;
      state_d         = cnt_q == CW'(CFG_BITS - 1) ? PARITY : SHIFT;
    end else if (beat && state_q == PARITY) begin
      state_d = IDLE;
      done_d  = cfg_data == par_q;
      err_d   = cfg_data != par_q;
      ctrl_d  = cfg_data == par_q ? shadow_q : ctrl_q;
    end
  end
  // State and output registers; the whole ctrl image updates on one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      shadow_q <= '0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      done_q   <= done_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      ctrl_q   <= ctrl_d;
    end
  end
endmodule

// File: tb/tb_sm_config_loader.sv
// tb_sm_config_loader: table-driven frames with a scoreboard queue plus abort and reset corner cases
module tb_sm_config_loader;
  logic clk = 1'b0, rst_n = 1'b0, cfg_start = 1'b0, cfg_valid = 1'b0, cfg_data = 1'b0;
  logic cfg_ready, cfg_busy, cfg_done, cfg_err;
  logic [7:0] ctrl_left, ctrl_right, ctrl_top, ctrl_bottom;
  logic [31:0] ctrl_all;
  int checks = 0, failures = 0;
  typedef struct {logic [31:0] data; logic par; int stall; logic [31:0] exp_ctrl; logic exp_done; logic exp_err;} vec_t;
  typedef struct {logic [31:0] ctrl; logic done; logic err;} exp_t;
  vec_t vecs[5];
  exp_t sbq[$];
  exp_t e;
  assign ctrl_all = {ctrl_bottom, ctrl_top, ctrl_right, ctrl_left};
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  sm_config_loader dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .ctrl_left(ctrl_left), .ctrl_right(ctrl_right), .ctrl_top(ctrl_top), .ctrl_bottom(ctrl_bottom)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic b, input int stall, inout int cyc);
    for (int s = 0; s < 4 && $urandom_range(99) < stall; s++) begin
      cfg_valid = 1'b0;
      tick();
      cyc++;
    end
    cfg_valid = 1'b1;
    cfg_data  = b;
    tick();
    cyc++;
    cfg_valid = 1'b0;
  endtask
  task automatic start_frame;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("busy_after_start", 32'(cfg_busy), 32'd1);
    chk("ready_after_start", 32'(cfg_ready), 32'd1);
    chk("err_cleared_by_start", 32'(cfg_err), 32'd0);
  endtask
  task automatic check_commit(input string tag);
    e = sbq.pop_front();
    chk({tag, "_ctrl"}, ctrl_all, e.ctrl);
    chk({tag, "_done"}, 32'(cfg_done), 32'(e.done));
    chk({tag, "_err"}, 32'(cfg_err), 32'(e.err));
    chk({tag, "_busy_drop"}, 32'(cfg_busy), 32'd0);
    chk({tag, "_ready_drop"}, 32'(cfg_ready), 32'd0);
    tick();
    chk({tag, "_done_one_cycle"}, 32'(cfg_done), 32'd0);
    chk({tag, "_err_sticky"}, 32'(cfg_err), 32'(e.err));
  endtask
  task automatic check_reset_values(input string tag);
    chk({tag, "_ctrl"}, ctrl_all, 32'd0);
    chk({tag, "_flags"}, {28'd0, cfg_ready, cfg_busy, cfg_done, cfg_err}, 32'd0);
  endtask
  initial begin
    int cyc;
    logic [31:0] d;
    vecs[0] = '{32'hE4E41B1B, 1'b0, 0,  32'hE4E41B1B, 1'b1, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 1'b1, 0,  32'hE4E41B1B, 1'b0, 1'b1};
    vecs[2] = '{32'h80000001, 1'b0, 50, 32'h80000001, 1'b1, 1'b0};
    vecs[3] = '{32'h12345678, 1'b1, 0,  32'h12345678, 1'b1, 1'b0};
    vecs[4] = '{32'hA5A5A5A5, 1'b1, 30, 32'h12345678, 1'b0, 1'b1};
    repeat (3) tick();
    check_reset_values("reset_held");
    rst_n = 1'b1;
    tick();
    check_reset_values("reset_released");
    foreach (vecs[i]) begin
      sbq.push_back('{vecs[i].exp_ctrl, vecs[i].exp_done, vecs[i].exp_err});
      start_frame();
      cyc = 0;
      for (int b = 0; b < 32; b++) beat(vecs[i].data[b], vecs[i].stall, cyc);
      chk($sformatf("vec%0d_waiting_parity", i), {30'd0, cfg_ready, cfg_done}, 32'd2);
      beat(vecs[i].par, vecs[i].stall, cyc);
      if (vecs[i].stall == 0) chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'd33);
      check_commit($sformatf("vec%0d", i));
    end
    start_frame();
    cyc = 0;
    d = 32'h0F0F0F0F;
    for (int b = 0; b < 20; b++) beat(d[b], 0, cyc);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    chk("abort_ctrl_kept", ctrl_all, 32'h12345678);
    chk("abort_busy", 32'(cfg_busy), 32'd1);
    d = 32'h000000FE;
    for (int b = 0; b < 32; b++) beat(d[b], 0, cyc);
    chk("abort_32_beats_no_commit", ctrl_all, 32'h12345678);
    chk("abort_still_ready", 32'(cfg_ready), 32'd1);
    sbq.push_back('{32'h000000FE, 1'b1, 1'b0});
    beat(1'b1, 0, cyc);
    check_commit("abort_restart");
    start_frame();
    d = 32'hFFFF0000;
    for (int b = 0; b < 32; b++) beat(d[b], 0, cyc);
    cfg_valid = 1'b1;
    cfg_data  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midframe_reset");
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    cfg_valid = 1'b0;
    check_reset_values("after_reset_idle_beats");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
